// File: rtl/rvvi_trace_arbiter.sv
// Merges per-source RVVI retirement records through small elastic FIFOs into one
// round-robin arbitrated, registered valid/ready stream. Optional macro: RVVI_ARB_TIMESTAMP_EN.
module rvvi_trace_arbiter #(
    parameter int NSRC  = 2,
    parameter int DEPTH = 4,
    parameter int REC_W = 128,
    parameter int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NSRC-1:0]         src_valid_i,
    input  logic [NSRC*REC_W-1:0]   src_rec_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [REC_W-1:0]        out_rec_o,
    output logic [SRC_W-1:0]        out_src_o,
`ifdef RVVI_ARB_TIMESTAMP_EN
    output logic [31:0]             out_stamp_o,
`endif
    output logic [NSRC-1:0]         overflow_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int          PW = $clog2(DEPTH);
    localparam int unsigned NS = NSRC;

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t             state_q, state_d;
    logic [REC_W-1:0]   mem_q [NSRC][DEPTH];
    logic [PW-1:0]      wr_q  [NSRC];
    logic [PW-1:0]      rd_q  [NSRC];
    logic [PW:0]        cnt_q [NSRC];
    logic [SRC_W-1:0]   ptr_q;
    logic [REC_W-1:0]   rec_q;
    logic [SRC_W-1:0]   src_q;
    logic [NSRC-1:0]    ovf_q, ovf_d;
    logic [15:0]        drop_q, drop_d;

    logic [NSRC-1:0]    nonempty, push, pop, drop;
    logic [SRC_W-1:0]   gnt;
    logic               found, load;
    logic [16:0]        drop_sum;
    int unsigned        j;

`ifdef RVVI_ARB_TIMESTAMP_EN
    logic [31:0]        stamp_mem_q [NSRC][DEPTH];
    logic [31:0]        stamp_q;
    logic [31:0]        cyc_q;
`endif

    // Round-robin grant: first non-empty FIFO at or after the pointer, wrapping.
    always_comb begin
        nonempty = '0;
        gnt      = '0;
        found    = 1'b0;
        j        = 0;
        for (int unsigned k = 0; k < NS; k++) begin
            nonempty[k] = (cnt_q[k] != '0);
        end
        for (int unsigned i = 0; i < NS; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= NS) begin
                j = j - NS;
            end
            if (!found && nonempty[j]) begin
                found = 1'b1;
                gnt   = SRC_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (found) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready_i) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // A full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        pop      = '0;
        push     = '0;
        drop     = '0;
        drop_sum = {1'b0, drop_q};
        for (int unsigned k = 0; k < NS; k++) begin
            pop[k]   = load && (gnt == SRC_W'(k));
            push[k]  = src_valid_i[k] && ((cnt_q[k] < (PW+1)'(DEPTH)) || pop[k]);
            drop[k]  = src_valid_i[k] && !push[k];
            drop_sum = drop_sum + 17'(drop[k]);
        end
        drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        ovf_d  = ovf_q | drop;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            rec_q   <= '0;
            src_q   <= '0;
            ovf_q   <= '0;
            drop_q  <= '0;
            for (int unsigned k = 0; k < NS; k++) begin
                wr_q[k]  <= '0;
                rd_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            for (int unsigned k = 0; k < NS; k++) begin
                if (push[k]) begin
                    mem_q[k][wr_q[k]] <= src_rec_i[k*REC_W +: REC_W];
                    wr_q[k]           <= wr_q[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_q[k] <= rd_q[k] + 1'b1;
                end
                cnt_q[k] <= cnt_q[k] + (PW+1)'(push[k]) - (PW+1)'(pop[k]);
            end
            if (load) begin
                rec_q <= mem_q[gnt][rd_q[gnt]];
                src_q <= gnt;
                ptr_q <= (gnt == SRC_W'(NS - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

`ifdef RVVI_ARB_TIMESTAMP_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cyc_q   <= '0;
            stamp_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            for (int unsigned k = 0; k < NS; k++) begin
                if (push[k]) begin
                    stamp_mem_q[k][wr_q[k]] <= cyc_q;
                end
            end
            if (load) begin
                stamp_q <= stamp_mem_q[gnt][rd_q[gnt]];
            end
        end
    end

    assign out_stamp_o = stamp_q;
`endif

    assign out_valid_o = (state_q == ST_FULL);
    assign out_rec_o   = rec_q;
    assign out_src_o   = src_q;
    assign overflow_o  = ovf_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_rvvi_trace_arbiter.sv
// Directed bench for rvvi_trace_arbiter (NSRC=2, DEPTH=4, REC_W=128), stamp checked
// only when RVVI_ARB_TIMESTAMP_EN is defined.
module tb_rvvi_trace_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   src_valid;
    logic [255:0] src_rec;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_rec;
    logic         out_src;
    logic [1:0]   overflow;
    logic [15:0]  drop_cnt;
`ifdef RVVI_ARB_TIMESTAMP_EN
    logic [31:0]  out_stamp;
`endif

    int vectors = 0;
    int miscompares = 0;

    rvvi_trace_arbiter #(.NSRC(2), .DEPTH(4), .REC_W(128)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .src_valid_i (src_valid),
        .src_rec_i   (src_rec),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_rec_o   (out_rec),
        .out_src_o   (out_src),
`ifdef RVVI_ARB_TIMESTAMP_EN
        .out_stamp_o (out_stamp),
`endif
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        src_valid = '0;
        src_rec   = '0;
        out_ready = 1'b1;
        step(2);

        // Reset state
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_rec",   out_rec,         128'd0);
        chk("rst_src",   128'(out_src),   128'd0);
        chk("rst_ovf",   128'(overflow),  128'd0);
        chk("rst_drop",  128'(drop_cnt),  128'd0);
`ifdef RVVI_ARB_TIMESTAMP_EN
        chk("rst_stamp", 128'(out_stamp), 128'd0);
`endif

        // Single record at cycle 5, visible at cycle 7
        rst_n = 1'b1;
        step(5);
        src_valid = 2'b01;
        src_rec[127:0] = 128'hA5;
        step(1);
        src_valid = '0;
        chk("single_lat6", 128'(out_valid), 128'd0);
        step(1);
        chk("single_valid", 128'(out_valid), 128'd1);
        chk("single_rec",   out_rec,         128'hA5);
        chk("single_src",   128'(out_src),   128'd0);
`ifdef RVVI_ARB_TIMESTAMP_EN
        chk("single_stamp", 128'(out_stamp), 128'd5);
`endif
        step(1);
        chk("single_done", 128'(out_valid), 128'd0);

        // Fairness from pointer 0: both sources push for 4 cycles
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            src_valid = (c < 4) ? 2'b11 : 2'b00;
            src_rec[127:0]   = 128'h100 + 128'(c);
            src_rec[255:128] = 128'h200 + 128'(c);
            if (c >= 2) begin
                chk("fair_valid", 128'(out_valid), 128'd1);
                chk("fair_src",   128'(out_src),   128'((c - 2) % 2));
                chk("fair_rec",   out_rec, (((c - 2) % 2) == 1 ? 128'h200 : 128'h100) + 128'((c - 2) / 2));
            end
            step(1);
        end
        chk("fair_empty", 128'(out_valid), 128'd0);
        chk("fair_drop",  128'(drop_cnt),  128'd0);

        // Back-pressure: src 1 pushes 7 records with ready low
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            src_valid = 2'b10;
            src_rec[255:128] = 128'h300 + 128'(c);
            step(1);
            if (c >= 1) begin
                chk("bp_hold_valid", 128'(out_valid), 128'd1);
                chk("bp_hold_rec",   out_rec,         128'h300);
                chk("bp_hold_src",   128'(out_src),   128'd1);
            end
        end
        src_valid = '0;
        chk("bp_drop", 128'(drop_cnt), 128'd2);
        chk("bp_ovf",  128'(overflow), 128'b10);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_drain", out_rec, 128'h300 + 128'(c));
            step(1);
        end
        chk("bp_empty", 128'(out_valid), 128'd0);

        // Push on full FIFO 0 together with a handshake
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            src_valid = 2'b01;
            src_rec[127:0] = 128'h400 + 128'(c);
            step(1);
        end
        src_rec[127:0] = 128'h405;
        out_ready = 1'b1;
        chk("pf_head", out_rec, 128'h400);
        step(1);
        src_valid = '0;
        chk("pf_drop", 128'(drop_cnt), 128'd2);
        chk("pf_ovf",  128'(overflow), 128'b10);
        for (int c = 1; c < 6; c++) begin
            chk("pf_drain", out_rec, 128'h400 + 128'(c));
            step(1);
        end
        chk("pf_empty", 128'(out_valid), 128'd0);

        // Saturation: two drops per cycle once both FIFOs and the output are full
        out_ready = 1'b0;
        src_valid = 2'b11;
        step(30000);
        chk("sat_mid",  128'(drop_cnt), 128'd59993);
        step(5000);
        chk("sat_top",  128'(drop_cnt), 128'hFFFF);
        step(10);
        chk("sat_hold", 128'(drop_cnt), 128'hFFFF);
        chk("sat_ovf",  128'(overflow), 128'b11);

        // Mid-stream reset with 3 records queued behind a valid output
        src_valid = '0;
        out_ready = 1'b1;
        step(5);
        out_ready = 1'b0;
        chk("mr_pre_valid", 128'(out_valid), 128'd1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mr_valid", 128'(out_valid), 128'd0);
        chk("mr_ovf",   128'(overflow),  128'd0);
        chk("mr_drop",  128'(drop_cnt),  128'd0);
        out_ready = 1'b1;
        src_valid = 2'b11;
        src_rec[127:0]   = 128'h500;
        src_rec[255:128] = 128'h600;
        step(1);
        src_valid = '0;
        chk("mr_lat", 128'(out_valid), 128'd0);
        step(1);
        chk("mr_first_src", 128'(out_src), 128'd0);
        chk("mr_first_rec", out_rec,       128'h500);
        step(1);
        chk("mr_second_src", 128'(out_src), 128'd1);
        chk("mr_second_rec", out_rec,       128'h600);
        step(1);
        chk("mr_empty", 128'(out_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
